// File: rtl/mips_pkg.sv
// mips_pkg: shared redirect-priority encoding and fetch-stage default constants.
package mips_pkg;
  typedef enum logic [2:0] {RD_NONE, RD_BR, RD_J, RD_JR, RD_EXC} rd_pri_e;
  localparam logic [31:0] RESET_VECTOR_32 = 32'hBFC0_0000;
  localparam logic [31:0] EXC_VECTOR_32 = 32'h8000_0180;
  localparam int INC_DEF = 4;
endpackage

// File: rtl/pc_target_gen.sv
// pc_target_gen: combinational next-PC candidates and the winning redirect target.
module pc_target_gen
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INC = INC_DEF,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_32)
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic              br_taken_i,
  input  logic [15:0]       br_imm_i,
  input  logic              jump_i,
  input  logic [25:0]       jump_idx_i,
  input  logic              jr_i,
  input  logic [ADDR_W-1:0] jr_addr_i,
  input  logic              exc_i,
  output logic [ADDR_W-1:0] seq_o,
  output logic [ADDR_W-1:0] tgt_o,
  output rd_pri_e           pri_o
);
  logic [ADDR_W-1:0] br, jmp, jrt;
  assign seq_o = pc_i + ADDR_W'(INC);
  assign br = seq_o + {{(ADDR_W-18){br_imm_i[15]}}, br_imm_i, 2'b00};
  assign jmp = {seq_o[ADDR_W-1:28], jump_idx_i, 2'b00};
  assign jrt = {jr_addr_i[ADDR_W-1:2], 2'b00};
  always_comb begin
    pri_o = exc_i ? RD_EXC : jr_i ? RD_JR : jump_i ? RD_J : br_taken_i ? RD_BR : RD_NONE;
    tgt_o = exc_i ? EXC_VECTOR : jr_i ? jrt : jump_i ? jmp : br_taken_i ? br : seq_o;
  end
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: architectural PC register with BOOT/RUN fetch handshake and a
// one-entry redirect buffer for redirects that arrive while fetch cannot advance.
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int INC = INC_DEF,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_32),
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(EXC_VECTOR_32)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [15:0]       br_imm,
  input  logic              jump,
  input  logic [25:0]       jump_idx,
  input  logic              jr,
  input  logic [ADDR_W-1:0] jr_addr,
  input  logic              exc,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              fetch_valid,
  output logic              redirect_pending,
  output logic              misaligned
);
  typedef enum logic {BOOT, RUN} state_e;
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, buf_q, buf_d, tgt;
  rd_pri_e bpri_q, bpri_d, pri;
  logic pend_q, pend_d, mis_q, mis_d, adv, ev, use_buf, load;
  pc_target_gen #(.ADDR_W(ADDR_W), .INC(INC), .EXC_VECTOR(EXC_VECTOR)) u_gen (
    .pc_i(pc_q), .br_taken_i(br_taken), .br_imm_i(br_imm), .jump_i(jump),
    .jump_idx_i(jump_idx), .jr_i(jr), .jr_addr_i(jr_addr), .exc_i(exc),
    .seq_o(pc_plus), .tgt_o(tgt), .pri_o(pri)
  );
  always_comb begin
    state_d = RUN;
    adv = (state_q == RUN) & fetch_ready & ~stall;
    ev = pri != RD_NONE;
    // A pending entry wins over anything of lower rank, including "no event".
    use_buf = pend_q & (bpri_q > pri);
    // A buffered exception is never displaced by a non-exception redirect.
    load = ~adv & ev & ~(pend_q & (bpri_q == RD_EXC) & (pri != RD_EXC));
    pc_d = ~adv ? pc_q : use_buf ? buf_q : ev ? tgt : pc_plus;
    pend_d = adv ? 1'b0 : pend_q | ev;
    buf_d = load ? tgt : buf_q;
    bpri_d = load ? pri : bpri_q;
    mis_d = (pri == RD_JR) & (|jr_addr[1:0]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q <= RESET_VECTOR;
      buf_q <= '0;
      bpri_q <= RD_NONE;
      pend_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      buf_q <= buf_d;
      bpri_q <= bpri_d;
      pend_q <= pend_d;
      mis_q <= mis_d;
    end
  end
  assign pc = pc_q;
  assign fetch_valid = state_q == RUN;
  assign redirect_pending = pend_q;
  assign misaligned = mis_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed stimulus with a behavioural next-PC model checked every cycle.
module tb_pc_sequencer;
  logic clk = 0, rst_n = 0, stall = 0, br_taken = 0, jump = 0, jr = 0, exc = 0, fetch_ready = 1;
  logic [15:0] br_imm = 0;
  logic [25:0] jump_idx = 0;
  logic [31:0] jr_addr = 0;
  logic [31:0] pc, pc_plus;
  logic fetch_valid, redirect_pending, misaligned;
  int n_cmp = 0, n_bad = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_taken(br_taken), .br_imm(br_imm),
    .jump(jump), .jump_idx(jump_idx), .jr(jr), .jr_addr(jr_addr), .exc(exc),
    .fetch_ready(fetch_ready), .pc(pc), .pc_plus(pc_plus), .fetch_valid(fetch_valid),
    .redirect_pending(redirect_pending), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  bit m_boot = 1, m_pend = 0, m_mis = 0;
  logic [31:0] m_pc = 32'hBFC00000, m_buf = 0;
  int m_bpri = 0;

  // Model ranks: exc 4, jr 3, jump 2, branch 1, none 0.
  always @(posedge clk or negedge rst_n) begin
    int pri;
    logic [31:0] tgt, seq;
    bit adv;
    if (!rst_n) begin
      m_boot = 1; m_pc = 32'hBFC00000; m_pend = 0; m_mis = 0; m_bpri = 0;
    end else begin
      seq = m_pc + 32'd4;
      if (exc) begin pri = 4; tgt = 32'h80000180; end
      else if (jr) begin pri = 3; tgt = jr_addr & 32'hFFFFFFFC; end
      else if (jump) begin pri = 2; tgt = {seq[31:28], jump_idx, 2'b00}; end
      else if (br_taken) begin pri = 1; tgt = seq + {{14{br_imm[15]}}, br_imm, 2'b00}; end
      else begin pri = 0; tgt = seq; end
      adv = !m_boot && fetch_ready && !stall;
      m_mis = (pri == 3) && (jr_addr[1:0] != 2'b00);
      if (adv) begin
        m_pc = (m_pend && m_bpri > pri) ? m_buf : tgt;
        m_pend = 0;
      end else if (pri > 0 && !(m_pend && m_bpri == 4 && pri != 4)) begin
        m_buf = tgt; m_bpri = pri; m_pend = 1;
      end
      m_boot = 0;
    end
  end

  always @(negedge clk) if (rst_n) begin
    chk("pc", pc, m_pc);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("fetch_valid", {31'd0, fetch_valid}, {31'd0, !m_boot});
    chk("pending", {31'd0, redirect_pending}, {31'd0, m_pend});
    chk("misaligned", {31'd0, misaligned}, {31'd0, m_mis});
  end

  task automatic step();
    @(posedge clk);
    #1;
    br_taken = 0; jump = 0; jr = 0; exc = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    chk("boot_pc", pc, 32'hBFC00000);
    chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    chk("run_fv", {31'd0, fetch_valid}, 32'd1);
    chk("run_pc0", pc, 32'hBFC00000);
    step(); chk("seq1", pc, 32'hBFC00004);
    step(); chk("seq2", pc, 32'hBFC00008);
    jr = 1; jr_addr = 32'h00400010; step(); chk("jr_set", pc, 32'h00400010);
    br_taken = 1; br_imm = 16'hFFFC; step(); chk("br_back", pc, 32'h00400004);
    jr = 1; jr_addr = 32'h00400000; step();
    jump = 1; jump_idx = 26'h0100000; jr = 1; jr_addr = 32'h00500000; step();
    chk("jr_over_j", pc, 32'h00500000);
    fetch_ready = 0; jump = 1; jump_idx = 26'h0000040; step();
    chk("buf_pend", {31'd0, redirect_pending}, 32'd1);
    chk("buf_hold", pc, 32'h00500000);
    step(); chk("buf_hold2", pc, 32'h00500000);
    fetch_ready = 1; step();
    chk("buf_apply", pc, 32'h00000100);
    chk("buf_clr", {31'd0, redirect_pending}, 32'd0);
    stall = 1; exc = 1; step();
    chk("exc_pend", {31'd0, redirect_pending}, 32'd1);
    br_taken = 1; br_imm = 16'h0005; step();
    stall = 0; step();
    chk("exc_keep", pc, 32'h80000180);
    chk("exc_clr", {31'd0, redirect_pending}, 32'd0);
    jr = 1; jr_addr = 32'hFFFFFFFC; step(); step();
    chk("wrap", pc, 32'h00000000);
    jr = 1; jr_addr = 32'h00400006; step();
    chk("mis_pc", pc, 32'h00400004);
    chk("mis_hi", {31'd0, misaligned}, 32'd1);
    step();
    chk("mis_lo", {31'd0, misaligned}, 32'd0);
    chk("mis_seq", pc, 32'h00400008);
    for (int i = 0; i < 80; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      br_taken = ($urandom_range(0, 4) == 0); br_imm = 16'($urandom);
      jump = ($urandom_range(0, 6) == 0); jump_idx = 26'($urandom);
      jr = ($urandom_range(0, 6) == 0); jr_addr = $urandom;
      exc = ($urandom_range(0, 12) == 0);
      step();
    end
    stall = 0; fetch_ready = 0; jump = 1; jump_idx = 26'h3; step();
    chk("rst_pre_pend", {31'd0, redirect_pending}, 32'd1);
    #2 rst_n = 0;
    #1;
    chk("arst_pc", pc, 32'hBFC00000);
    chk("arst_pend", {31'd0, redirect_pending}, 32'd0);
    chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
    fetch_ready = 1;
    step(); step();
    rst_n = 1;
    step(); step(); step();
    chk("post_rst", pc, 32'hBFC00008);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
